reg_write_port: RTL and testbench

- Write-side driver for the decode-stage register bank; owns the bank's single write port.
- Merges two result sources:
  - the in-order pipeline writeback (MEM/WB), which is always accepted;
  - a long-latency unit (multiply/divide, or a cache-miss load), which uses a valid/ready handshake.
- Long-latency results wait in a small FIFO until the port is free.
- Exports a per-register pending mask so decode can stall on queued writes.

---
 rtl/reg_write_port.sv | 134 +++++++++++++
 tb/tb_reg_write_port.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_port.sv
// rtl/reg_write_port.sv - register bank write-port arbiter with a queued long-latency result path
// Defining WB_FORWARD_EN adds same-cycle forwarding of the write port to two read ids.
module reg_write_port #(
  parameter int FIFO_DEPTH = 2,
  parameter int PTR_W      = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        wb_valid,
  input  logic [4:0]  wb_reg_id,
  input  logic [31:0] wb_value,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_reg_id,
  input  logic [31:0] lu_value,
  output logic        control_reg_write,
  output logic [4:0]  reg_write_id,
  output logic [31:0] reg_write_value,
  output logic [31:0] reg_pending
`ifdef WB_FORWARD_EN
  ,
  input  logic [4:0]  rs_id,
  input  logic [4:0]  rt_id,
  output logic        rs_fwd_hit,
  output logic        rt_fwd_hit,
  output logic [31:0] rs_fwd_value,
  output logic [31:0] rt_fwd_value
`endif
);

  localparam int               CNT_W    = PTR_W + 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [4:0]            ent_id  [FIFO_DEPTH];
  logic [31:0]           ent_val [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] ent_vld;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count;

  logic fifo_empty;
  logic wb_issue;
  logic head_dead;
  logic fifo_issue;
  logic pop;
  logic push;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign fifo_empty = (count == '0);
  assign lu_ready   = (count != FULL_CNT);
  assign wb_issue   = wb_valid && (wb_reg_id != 5'd0);

  // A head already killed, or killed by this cycle's pipeline write, is retired
  // even while the pipeline owns the port, so it never blocks later entries.
  assign head_dead  = !ent_vld[rd_ptr] || (wb_issue && (ent_id[rd_ptr] == wb_reg_id));
  assign pop        = !fifo_empty && (!wb_issue || head_dead);
  assign fifo_issue = !wb_issue && !fifo_empty && ent_vld[rd_ptr];
  assign push       = lu_valid && lu_ready && (lu_reg_id != 5'd0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      ent_vld <= '0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (wb_issue && (ent_id[i] == wb_reg_id)) begin
          ent_vld[i] <= 1'b0;
        end
      end
      if (pop) begin
        ent_vld[rd_ptr] <= 1'b0;
        rd_ptr          <= next_ptr(rd_ptr);
      end
      // Push lands last so a same-cycle younger lu result survives the kill.
      if (push) begin
        ent_vld[wr_ptr] <= 1'b1;
        wr_ptr          <= next_ptr(wr_ptr);
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      ent_id[wr_ptr]  <= lu_reg_id;
      ent_val[wr_ptr] <= lu_value;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      control_reg_write <= 1'b0;
      reg_write_id      <= '0;
      reg_write_value   <= '0;
    end else begin
      control_reg_write <= wb_issue || fifo_issue;
      if (wb_issue) begin
        reg_write_id    <= wb_reg_id;
        reg_write_value <= wb_value;
      end else if (fifo_issue) begin
        reg_write_id    <= ent_id[rd_ptr];
        reg_write_value <= ent_val[rd_ptr];
      end
    end
  end

  always_comb begin
    reg_pending = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (ent_vld[i]) begin
        reg_pending[ent_id[i]] = 1'b1;
      end
    end
    reg_pending[0] = 1'b0;
  end

`ifdef WB_FORWARD_EN
  assign rs_fwd_hit   = control_reg_write && (reg_write_id == rs_id) && (rs_id != 5'd0);
  assign rt_fwd_hit   = control_reg_write && (reg_write_id == rt_id) && (rt_id != 5'd0);
  assign rs_fwd_value = rs_fwd_hit ? reg_write_value : 32'd0;
  assign rt_fwd_value = rt_fwd_hit ? reg_write_value : 32'd0;
`endif

endmodule

// File: tb/tb_reg_write_port.sv
// tb/tb_reg_write_port.sv - bench for reg_write_port: queue-level reference model plus directed vectors
module tb_reg_write_port;

  localparam int DEPTH = 2;

  logic        clock;
  logic        reset_n;
  logic        wb_valid;
  logic [4:0]  wb_reg_id;
  logic [31:0] wb_value;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_reg_id;
  logic [31:0] lu_value;
  logic        control_reg_write;
  logic [4:0]  reg_write_id;
  logic [31:0] reg_write_value;
  logic [31:0] reg_pending;
`ifdef WB_FORWARD_EN
  logic [4:0]  rs_id;
  logic [4:0]  rt_id;
  logic        rs_fwd_hit;
  logic        rt_fwd_hit;
  logic [31:0] rs_fwd_value;
  logic [31:0] rt_fwd_value;
`endif

  int checks = 0;
  int errors = 0;

  reg_write_port #(.FIFO_DEPTH(DEPTH), .PTR_W(1)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .wb_valid(wb_valid),
    .wb_reg_id(wb_reg_id),
    .wb_value(wb_value),
    .lu_valid(lu_valid),
    .lu_ready(lu_ready),
    .lu_reg_id(lu_reg_id),
    .lu_value(lu_value),
    .control_reg_write(control_reg_write),
    .reg_write_id(reg_write_id),
    .reg_write_value(reg_write_value),
    .reg_pending(reg_pending)
`ifdef WB_FORWARD_EN
    ,
    .rs_id(rs_id),
    .rt_id(rt_id),
    .rs_fwd_hit(rs_fwd_hit),
    .rt_fwd_hit(rt_fwd_hit),
    .rs_fwd_value(rs_fwd_value),
    .rt_fwd_value(rt_fwd_value)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h, required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the queue holds every accepted lu result in arrival order.
  typedef struct {
    logic [4:0]  id;
    logic [31:0] val;
    bit          vld;
  } ent_t;

  ent_t        q[$];
  ent_t        e;
  logic        exp_we;
  logic [4:0]  exp_id;
  logic [31:0] exp_val;
  logic [31:0] exp_pend;
  bit          m_ready;

  initial begin
    exp_we  = 1'b0;
    exp_id  = '0;
    exp_val = '0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        q.delete();
        exp_we  = 1'b0;
        exp_id  = '0;
        exp_val = '0;
      end
      exp_pend = '0;
      foreach (q[i]) if (q[i].vld) exp_pend[q[i].id] = 1'b1;
      m_ready = (q.size() < DEPTH);
      chk("m_we", 32'(control_reg_write), 32'(exp_we));
      chk("m_id", 32'(reg_write_id), 32'(exp_id));
      chk("m_val", reg_write_value, exp_val);
      chk("m_ready", 32'(lu_ready), 32'(m_ready));
      chk("m_pend", reg_pending, exp_pend);
      if (reset_n) begin
        exp_we = 1'b0;
        if (wb_valid && wb_reg_id != 5'd0) begin
          exp_we  = 1'b1;
          exp_id  = wb_reg_id;
          exp_val = wb_value;
          foreach (q[i]) if (q[i].id == wb_reg_id) q[i].vld = 1'b0;
          if (q.size() > 0 && !q[0].vld) void'(q.pop_front());
        end else if (q.size() > 0) begin
          e = q.pop_front();
          if (e.vld) begin
            exp_we  = 1'b1;
            exp_id  = e.id;
            exp_val = e.val;
          end
        end
        if (lu_valid && m_ready && lu_reg_id != 5'd0) begin
          e.id  = lu_reg_id;
          e.val = lu_value;
          e.vld = 1'b1;
          q.push_back(e);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  bit hs;

  initial begin
    reset_n   = 1'b0;
    wb_valid  = 1'b0;
    wb_reg_id = '0;
    wb_value  = '0;
    lu_valid  = 1'b1;
    lu_reg_id = 5'd5;
    lu_value  = 32'hDEADBEEF;
`ifdef WB_FORWARD_EN
    rs_id = '0;
    rt_id = '0;
`endif
    repeat (3) cyc();
    reset_n = 1'b1;
    settle();
    chk("rst_we", 32'(control_reg_write), 32'd0);
    chk("rst_pend", reg_pending, 32'd0);
    chk("rst_ready", 32'(lu_ready), 32'd1);
    cyc();
    lu_valid = 1'b0;
    chk("lu_lat1_we", 32'(control_reg_write), 32'd0);
    chk("lu_lat1_pend", reg_pending, 32'h20);
    cyc();
    chk("lu_lat2_we", 32'(control_reg_write), 32'd1);
    chk("lu_lat2_id", 32'(reg_write_id), 32'd5);
    chk("lu_lat2_val", reg_write_value, 32'hDEADBEEF);
    cyc();

    wb_valid = 1'b1; wb_reg_id = 5'd3; wb_value = 32'h11;
    lu_valid = 1'b1; lu_reg_id = 5'd7; lu_value = 32'h70;
    cyc();
    lu_reg_id = 5'd8; lu_value = 32'h80;
    cyc();
    lu_valid = 1'b0;
    settle();
    chk("full_ready", 32'(lu_ready), 32'd0);
    chk("full_pend", reg_pending, 32'h180);
    chk("wb_id", 32'(reg_write_id), 32'd3);
    wb_valid = 1'b0;
    cyc();
    chk("drain7_id", 32'(reg_write_id), 32'd7);
    chk("drain7_val", reg_write_value, 32'h70);
    cyc();
    chk("drain8_id", 32'(reg_write_id), 32'd8);
    chk("drain8_val", reg_write_value, 32'h80);
    chk("drain_pend", reg_pending, 32'd0);
    cyc();

    lu_valid = 1'b1; lu_reg_id = 5'd9; lu_value = 32'hAAAA;
    cyc();
    lu_valid = 1'b0;
    wb_valid = 1'b1; wb_reg_id = 5'd9; wb_value = 32'hBBBB;
    settle();
    chk("kill_pend_pre", reg_pending, 32'h200);
    cyc();
    chk("kill_val", reg_write_value, 32'hBBBB);
    chk("kill_pend_post", reg_pending, 32'd0);
    wb_valid = 1'b0;
    cyc();
    chk("kill_noissue", 32'(control_reg_write), 32'd0);
    chk("kill_hold_val", reg_write_value, 32'hBBBB);
    cyc();

    wb_valid = 1'b1; wb_reg_id = 5'd0; wb_value = 32'h55;
    lu_valid = 1'b1; lu_reg_id = 5'd0; lu_value = 32'h66;
    settle();
    chk("r0_ready", 32'(lu_ready), 32'd1);
    cyc();
    chk("r0_we1", 32'(control_reg_write), 32'd0);
    cyc();
    chk("r0_we2", 32'(control_reg_write), 32'd0);
    wb_valid = 1'b0; lu_valid = 1'b0;
    cyc();

    wb_valid = 1'b1; wb_reg_id = 5'd14; wb_value = 32'hE1;
    lu_valid = 1'b1; lu_reg_id = 5'd14; lu_value = 32'hE2;
    cyc();
    chk("waw_wb_val", reg_write_value, 32'hE1);
    wb_valid = 1'b0; lu_valid = 1'b0;
    cyc();
    chk("waw_lu_we", 32'(control_reg_write), 32'd1);
    chk("waw_lu_val", reg_write_value, 32'hE2);
    cyc();

    wb_valid = 1'b1; wb_reg_id = 5'd20; wb_value = 32'h2000;
    lu_valid = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      lu_reg_id = 5'(k);
      lu_value  = 32'(k) * 32'h101;
      hs = 1'b0;
      for (int t = 0; t < 8 && !hs; t++) begin
        settle();
        hs = lu_ready;
        cyc();
      end
      chk("stream_handshake", 32'(hs), 32'd1);
      if (k == 2) wb_valid = 1'b0;
    end
    lu_valid = 1'b0;
    repeat (3) cyc();
    chk("stream_last_id", 32'(reg_write_id), 32'd6);
    chk("stream_last_val", reg_write_value, 32'h606);
    chk("stream_pend", reg_pending, 32'd0);

    wb_valid = 1'b1; wb_reg_id = 5'd21; wb_value = 32'h21;
    lu_valid = 1'b1; lu_reg_id = 5'd10; lu_value = 32'hA;
    cyc();
    lu_reg_id = 5'd11; lu_value = 32'hB;
    cyc();
    lu_valid = 1'b0;
    settle();
    chk("mid_pend", reg_pending, 32'hC00);
    reset_n = 1'b0;
    settle();
    chk("mid_rst_we", 32'(control_reg_write), 32'd0);
    chk("mid_rst_pend", reg_pending, 32'd0);
    chk("mid_rst_ready", 32'(lu_ready), 32'd1);
    wb_valid = 1'b0;
    cyc();
    reset_n = 1'b1;
    cyc();
    chk("post_rst_we1", 32'(control_reg_write), 32'd0);
    cyc();
    chk("post_rst_we2", 32'(control_reg_write), 32'd0);

`ifdef WB_FORWARD_EN
    wb_valid = 1'b1; wb_reg_id = 5'd12; wb_value = 32'h1234;
    rs_id = 5'd12; rt_id = 5'd0;
    cyc();
    wb_valid = 1'b0;
    chk("fwd_rs_hit", 32'(rs_fwd_hit), 32'd1);
    chk("fwd_rs_val", rs_fwd_value, 32'h1234);
    chk("fwd_rt_hit", 32'(rt_fwd_hit), 32'd0);
    chk("fwd_rt_val", rt_fwd_value, 32'd0);
    cyc();
    chk("fwd_idle_hit", 32'(rs_fwd_hit), 32'd0);
`endif

    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
